// File: rtl/apb_completer_pkg.sv
// Shared types and defaults for the APB wait-state completer.
// Used by apb_wait_completer (optional APB_COMPLETER_PSTRB_EN byte strobes) and its regfile.
package apb_completer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    localparam int unsigned AddrWDefault = 8;
    localparam int unsigned DataWDefault = 16;
    localparam int unsigned DepthDefault = 16;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_completer_regfile.sv
// DEPTH x DATA_W register storage: byte-enabled synchronous write, asynchronous read,
// synchronous clear.
module apb_completer_regfile
    import apb_completer_pkg::*;
#(
    parameter int unsigned DataW = DataWDefault,
    parameter int unsigned Depth = DepthDefault,
    localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned Lanes = byte_lanes(DataW)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IdxW-1:0]  waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [Lanes-1:0] be_i,
    input  logic [IdxW-1:0]  raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int unsigned l = 0; l < Lanes; l++) begin
                if (be_i[l]) begin
                    mem_q[waddr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_wait_completer.sv
// APB completer with register file, programmable wait states and out-of-range PSLVERR.
// Define APB_COMPLETER_PSTRB_EN to add the PSTRB byte-strobe input.
module apb_wait_completer
    import apb_completer_pkg::*;
#(
    parameter int unsigned ADDR_W      = AddrWDefault,
    parameter int unsigned DATA_W      = DataWDefault,
    parameter int unsigned DEPTH       = DepthDefault,
    parameter int unsigned WAIT_CYCLES = 2,
    localparam int unsigned Lanes = byte_lanes(DATA_W)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_COMPLETER_PSTRB_EN
    input  logic [Lanes-1:0]  PSTRB,
`endif
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [CntW-1:0] CntLoad  = CntW'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [Lanes-1:0]  be;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] rf_rdata;

`ifdef APB_COMPLETER_PSTRB_EN
    logic [Lanes-1:0]  strb_q, strb_d;
    assign be = strb_q;
`else
    assign be = '1;
`endif

    // Full-width unsigned compare so upper address bits never alias into the array.
    assign in_range = ({1'b0, PADDR} < DepthLim);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef APB_COMPLETER_PSTRB_EN
        strb_d  = strb_q;
`endif

        case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (PENABLE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        mem_we  = write_q & ~err_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A setup phase seen in either state (re)captures the whole transfer.
        if (PSEL && !PENABLE) begin
            addr_d  = PADDR[IdxW-1:0];
            write_d = PWRITE;
            wdata_d = PWDATA;
            err_d   = ~in_range;
            cnt_d   = CntLoad;
`ifdef APB_COMPLETER_PSTRB_EN
            strb_d  = PSTRB;
`endif
            if (!PWRITE && in_range) begin
                rdata_d = rf_rdata;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef APB_COMPLETER_PSTRB_EN
            strb_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef APB_COMPLETER_PSTRB_EN
            strb_q  <= strb_d;
`endif
        end
    end

    always_comb begin
        PREADY  = (state_q == StAccess) && (cnt_q == '0);
        PSLVERR = PREADY & err_q;
        PRDATA  = (PREADY && !write_q && !err_q) ? rdata_q : '0;
    end

    apb_completer_regfile #(
        .DataW (DATA_W),
        .Depth (DEPTH)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .be_i    (be),
        .raddr_i (PADDR[IdxW-1:0]),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_apb_wait_completer.sv
// Directed bench for apb_wait_completer: one 2-wait and one zero-wait instance on a shared bus.
// PSTRB vectors run only when APB_COMPLETER_PSTRB_EN is defined.
module tb_apb_wait_completer;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel2, psel0, penable, pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [1:0]  pstrb;
    logic [15:0] prdata2, prdata0;
    logic        pready2, pready0, pslverr2, pslverr0;

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb_wait_completer #(.ADDR_W(8), .DATA_W(16), .DEPTH(16), .WAIT_CYCLES(2)) dut2 (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel2),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
`ifdef APB_COMPLETER_PSTRB_EN
        .PSTRB   (pstrb),
`endif
        .PRDATA  (prdata2),
        .PREADY  (pready2),
        .PSLVERR (pslverr2)
    );

    apb_wait_completer #(.ADDR_W(8), .DATA_W(16), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel0),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
`ifdef APB_COMPLETER_PSTRB_EN
        .PSTRB   (pstrb),
`endif
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel2   = 1'b0;
        psel0   = 1'b0;
        penable = 1'b0;
    endtask

    // Returns with the bus still in the access phase, so a following call is back-to-back.
    task automatic apb_xfer(input bit sel0, input bit wr, input logic [7:0] addr,
                            input logic [15:0] wdata, input logic [1:0] strb, input bit mangle,
                            output logic [15:0] rdata, output logic err, output int n);
        logic rdy;
        @(negedge pclk);
        psel0   = sel0;
        psel2   = ~sel0;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(negedge pclk);
        penable = 1'b1;
        if (mangle) begin
            paddr  = addr + 8'd1;
            pwdata = 16'h5555;
        end
        n   = 1;
        rdy = sel0 ? pready0 : pready2;
        while (!rdy && n < 20) begin
            @(negedge pclk);
            n++;
            rdy = sel0 ? pready0 : pready2;
        end
        check_eq("xfer_ready", rdy, 1);
        rdata = sel0 ? prdata0 : prdata2;
        err   = sel0 ? pslverr0 : pslverr2;
    endtask

    task automatic do_write(input bit sel0, input logic [7:0] a, input logic [15:0] d,
                            input logic [1:0] s, input logic exp_err, input string tag);
        logic [15:0] rd;
        logic        er;
        int          n;
        apb_xfer(sel0, 1'b1, a, d, s, 1'b0, rd, er, n);
        check_eq({tag, "_err"}, er, exp_err);
        check_eq({tag, "_cycles"}, n, sel0 ? 1 : 3);
    endtask

    task automatic do_read(input bit sel0, input logic [7:0] a, input logic [15:0] exp_d,
                           input logic exp_err, input string tag);
        logic [15:0] rd;
        logic        er;
        int          n;
        apb_xfer(sel0, 1'b0, a, 16'h0, 2'b11, 1'b0, rd, er, n);
        check_eq({tag, "_data"}, rd, exp_d);
        check_eq({tag, "_err"}, er, exp_err);
        check_eq({tag, "_cycles"}, n, sel0 ? 1 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          n;

        preset = 1'b1; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 2'b11;
        repeat (3) @(negedge pclk);
        check_eq("rst_pready", pready2, 0);
        check_eq("rst_pslverr", pslverr2, 0);
        check_eq("rst_prdata", prdata2, 0);
        check_eq("rst_pready0", pready0, 0);
        preset = 1'b0;

        // Two-wait write then read of addr 0
        do_write(1'b0, 8'd0, 16'hFFFF, 2'b11, 1'b0, "w0");
        bus_idle();
        do_read(1'b0, 8'd0, 16'hFFFF, 1'b0, "r0");
        bus_idle();

        // Zero-wait back-to-back write/read
        do_write(1'b1, 8'd1, 16'hFEFE, 2'b11, 1'b0, "w1_zw");
        do_read(1'b1, 8'd1, 16'hFEFE, 1'b0, "r1_zw");
        bus_idle();

        // Out-of-range accesses and the DEPTH boundary
        do_write(1'b0, 8'd16, 16'hABCD, 2'b11, 1'b1, "w16_err");
        bus_idle();
        do_read(1'b0, 8'h20, 16'h0, 1'b1, "r20_err");
        do_read(1'b0, 8'd0, 16'hFFFF, 1'b0, "r0_after_err");
        do_read(1'b0, 8'd15, 16'h0, 1'b0, "r15");
        do_read(1'b0, 8'hFF, 16'h0, 1'b1, "rff_err");
        bus_idle();

        // PADDR/PWDATA changed during the access phase
        apb_xfer(1'b0, 1'b1, 8'd2, 16'hAAAA, 2'b11, 1'b1, rd, er, n);
        check_eq("mangle_err", er, 0);
        bus_idle();
        do_read(1'b0, 8'd2, 16'hAAAA, 1'b0, "r2_mangle");
        do_read(1'b0, 8'd3, 16'h0, 1'b0, "r3_mangle");
        bus_idle();

        // Abort: PSEL dropped during a wait state
        @(negedge pclk);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd4; pwdata = 16'h1234;
        @(negedge pclk);
        penable = 1'b1;
        check_eq("abort_wait_pready", pready2, 0);
        @(negedge pclk);
        psel2 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_eq("abort_pready", pready2, 0);
        end
        do_read(1'b0, 8'd4, 16'h0, 1'b0, "r4_abort");
        bus_idle();

        // Stray access phase while idle
        @(negedge pclk);
        psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_eq("stray_pready", pready2, 0);
        end
        bus_idle();
        do_read(1'b0, 8'd0, 16'hFFFF, 1'b0, "r0_stray");
        bus_idle();

        // New setup in the middle of an access restarts the transfer
        @(negedge pclk);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 16'h1111;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        penable = 1'b0; paddr = 8'd8; pwdata = 16'h2222;
        @(negedge pclk);
        penable = 1'b1;
        check_eq("resetup_w1", pready2, 0);
        @(negedge pclk);
        check_eq("resetup_w2", pready2, 0);
        @(negedge pclk);
        check_eq("resetup_done", pready2, 1);
        bus_idle();
        do_read(1'b0, 8'd7, 16'h0, 1'b0, "r7_resetup");
        do_read(1'b0, 8'd8, 16'h2222, 1'b0, "r8_resetup");
        bus_idle();

`ifdef APB_COMPLETER_PSTRB_EN
        do_write(1'b0, 8'd5, 16'hFFFF, 2'b11, 1'b0, "w5_full");
        do_write(1'b0, 8'd5, 16'h0000, 2'b01, 1'b0, "w5_lane0");
        do_read(1'b0, 8'd5, 16'hFF00, 1'b0, "r5_strb");
        do_write(1'b0, 8'd5, 16'h1234, 2'b00, 1'b0, "w5_none");
        do_read(1'b0, 8'd5, 16'hFF00, 1'b0, "r5_nostrb");
        bus_idle();
`endif

        // Reset asserted one cycle before PREADY would rise
        @(negedge pclk);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd6; pwdata = 16'h7777;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        check_eq("midrst_pready", pready2, 0);
        check_eq("midrst_prdata", prdata2, 0);
        preset = 1'b0; psel2 = 1'b0; penable = 1'b0;
        do_read(1'b0, 8'd0, 16'h0, 1'b0, "r0_cleared");
        do_read(1'b0, 8'd6, 16'h0, 1'b0, "r6_cleared");
        do_read(1'b0, 8'd8, 16'h0, 1'b0, "r8_cleared");
        bus_idle();
        do_read(1'b1, 8'd1, 16'h0, 1'b0, "r1_zw_cleared");
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
